// File: rtl/rot_stepper_pkg.sv
// Shared encodings for the rotate-stepper slice: FSM states, step direction,
// and the 3-bit amount stepping helpers.
package rot_stepper_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    function automatic logic [2:0] next_amt(input logic [2:0] amt, input logic dir);
        return (dir == DIR_DN) ? amt - 3'd1 : amt + 3'd1;
    endfunction

    function automatic logic amt_wraps(input logic [2:0] amt, input logic dir);
        return (dir == DIR_DN) ? (amt == 3'd0) : (amt == 3'd7);
    endfunction

endpackage

// File: rtl/rot_stepper_if.sv
// Control/data bundle between the stepper and whatever drives it; the
// a/amt pair also feeds the downstream rotate-right shifter.
interface rot_stepper_if;
    logic       load;
    logic [7:0] din;
    logic       start;
    logic       stop;
    logic       dir;
    logic       step_once;
    logic [7:0] a;
    logic [2:0] amt;
    logic       running;
    logic       step_tick;
    logic       wrap;

    modport master (
        output load, din, start, stop, dir, step_once,
        input  a, amt, running, step_tick, wrap
    );

    modport slave (
        input  load, din, start, stop, dir, step_once,
        output a, amt, running, step_tick, wrap
    );
endinterface

// File: rtl/rot_tick_gen.sv
// Mod-DIV_MAX period counter with enable and synchronous clear; tc_o marks
// the final count of each period while enabled.
module rot_tick_gen #(
    parameter int DIV_MAX = 4,
    parameter int DIV_W   = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_MAX - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rot_stepper.sv
// Pattern/amount holder for the rotate-right shifter: steps amt automatically
// every DIV_MAX cycles in RUN, or once per step_once strobe in IDLE.
module rot_stepper
    import rot_stepper_pkg::*;
#(
    parameter int DIV_MAX = 4,
    parameter int DIV_W   = 23
) (
    input  logic         clk,
    input  logic         reset,
    rot_stepper_if.slave bus
);
    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [2:0] amt_q, amt_d;
    logic       running_q, running_d;
    logic       tick_q, tick_d;
    logic       wrap_q, wrap_d;

    logic is_idle, is_run, tc, clr, step_ev;

    assign is_idle = (state_q == ST_IDLE);
    assign is_run  = (state_q == ST_RUN);

    // A start seen while already running must not restart the period.
    assign clr = bus.load || bus.stop || (bus.start && is_idle);

    assign step_ev = !bus.load && !bus.stop &&
                     (is_idle ? (bus.step_once && !bus.start) : tc);

    rot_tick_gen #(
        .DIV_MAX (DIV_MAX),
        .DIV_W   (DIV_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en_i  (is_run),
        .clr_i (clr),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.load) begin
            if (bus.stop) begin
                state_d = ST_IDLE;
            end else if (bus.start && is_idle) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        a_d       = a_q;
        amt_d     = amt_q;
        running_d = (state_d == ST_RUN);
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        if (bus.load) begin
            a_d   = bus.din;
            amt_d = 3'd0;
        end else if (step_ev) begin
            amt_d  = next_amt(amt_q, bus.dir);
            tick_d = 1'b1;
            wrap_d = amt_wraps(amt_q, bus.dir);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= 8'h00;
            amt_q     <= 3'd0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            amt_q     <= amt_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.amt       = amt_q;
    assign bus.running   = running_q;
    assign bus.step_tick = tick_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_rot_stepper.sv
// Bench for rot_stepper: a DIV_MAX=4 and a DIV_MAX=1 instance share stimulus;
// expectations go into a queue when driven and are checked one edge later.
module tb_rot_stepper;
    logic clk;
    logic rst_r;
    logic load_r, start_r, stop_r, dir_r, so_r;
    logic [7:0] din_r;

    rot_stepper_if if4 ();
    rot_stepper_if if1 ();

    assign if4.load = load_r;   assign if1.load = load_r;
    assign if4.din = din_r;     assign if1.din = din_r;
    assign if4.start = start_r; assign if1.start = start_r;
    assign if4.stop = stop_r;   assign if1.stop = stop_r;
    assign if4.dir = dir_r;     assign if1.dir = dir_r;
    assign if4.step_once = so_r; assign if1.step_once = so_r;

    rot_stepper #(.DIV_MAX(4), .DIV_W(23)) dut4 (.clk(clk), .reset(rst_r), .bus(if4.slave));
    rot_stepper #(.DIV_MAX(1), .DIV_W(1))  dut1 (.clk(clk), .reset(rst_r), .bus(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       ld;
        logic [7:0] din;
        logic       st, sp, dr, so;
        logic [7:0] ea;
        logic [2:0] eamt;
        logic       erun, etk, ewr;
        logic [7:0] ey;
    } vec_t;

    typedef struct {
        bit         which;
        int         tag;
        logic [7:0] a;
        logic [2:0] amt;
        logic       run, tk, wr;
        logic [7:0] y;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] yv [8] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

    function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] t;
        t = {x, x} >> n;
        return t[7:0];
    endfunction

    function automatic vec_t mk(input logic ld, input logic [7:0] din, input logic st,
                                input logic sp, input logic dr, input logic so,
                                input logic [7:0] ea, input logic [2:0] eamt,
                                input logic erun, input logic etk, input logic ewr,
                                input logic [7:0] ey);
        vec_t v;
        v.ld = ld; v.din = din; v.st = st; v.sp = sp; v.dr = dr; v.so = so;
        v.ea = ea; v.eamt = eamt; v.erun = erun; v.etk = etk; v.ewr = ewr; v.ey = ey;
        return v;
    endfunction

    task automatic check_pop();
        exp_t e;
        logic [7:0] ga;
        logic [2:0] gamt;
        logic grun, gtk, gwr;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: queue empty, expected one pending record");
            return;
        end
        e = exp_q.pop_front();
        ga   = e.which ? if1.a : if4.a;
        gamt = e.which ? if1.amt : if4.amt;
        grun = e.which ? if1.running : if4.running;
        gtk  = e.which ? if1.step_tick : if4.step_tick;
        gwr  = e.which ? if1.wrap : if4.wrap;
        if ({ga, gamt, grun, gtk, gwr, rotr(ga, gamt)} !== {e.a, e.amt, e.run, e.tk, e.wr, e.y}) begin
            n_err++;
            $display("FAIL div%0d step %0d: got a=%h amt=%0d run=%b tick=%b wrap=%b y=%h, want a=%h amt=%0d run=%b tick=%b wrap=%b y=%h",
                     e.which ? 1 : 4, e.tag, ga, gamt, grun, gtk, gwr, rotr(ga, gamt),
                     e.a, e.amt, e.run, e.tk, e.wr, e.y);
        end
    endtask

    task automatic cyc(input bit which, input vec_t v, input int tag);
        exp_t e;
        load_r = v.ld; din_r = v.din; start_r = v.st; stop_r = v.sp; dir_r = v.dr; so_r = v.so;
        e.which = which; e.tag = tag; e.a = v.ea; e.amt = v.eamt;
        e.run = v.erun; e.tk = v.etk; e.wr = v.ewr; e.y = v.ey;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic check_reset(input int tag);
        n_chk++;
        if ({if4.a, if4.amt, if4.running, if4.step_tick, if4.wrap,
             if1.a, if1.amt, if1.running, if1.step_tick, if1.wrap} !== 30'd0) begin
            n_err++;
            $display("FAIL reset %0d: got div4 a=%h amt=%0d run=%b tick=%b wrap=%b div1 a=%h amt=%0d run=%b tick=%b wrap=%b, want all zero",
                     tag, if4.a, if4.amt, if4.running, if4.step_tick, if4.wrap,
                     if1.a, if1.amt, if1.running, if1.step_tick, if1.wrap);
        end
    endtask

    task automatic idle_inputs(input logic d);
        load_r = 0; din_r = 8'h00; start_r = 0; stop_r = 0; dir_r = d; so_r = 0;
    endtask

    initial begin
        rst_r = 1'b0;
        idle_inputs(1'b0);
        #1 rst_r = 1'b1;
        #2 check_reset(0);
        @(negedge clk) rst_r = 1'b0;

        // Run a little, then reset asynchronously while a step_tick is high.
        cyc(0, mk(1, 8'h3C, 0, 0, 0, 0, 8'h3C, 0, 0, 0, 0, 8'h3C), 100);
        cyc(0, mk(0, 8'h00, 1, 0, 0, 0, 8'h3C, 0, 1, 0, 0, 8'h3C), 101);
        for (int i = 0; i < 3; i++)
            cyc(0, mk(0, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 1, 0, 0, 8'h3C), 102 + i);
        cyc(0, mk(0, 8'h00, 0, 0, 0, 0, 8'h3C, 1, 1, 1, 0, 8'h1E), 105);
        #2 rst_r = 1'b1;
        #1 check_reset(1);
        @(negedge clk) rst_r = 1'b0;

        tbl.push_back(mk(1, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0, 0, 0, 8'h81));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h01, 0, 1, 0, 0, 8'h01));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 0, 1, 0, 0, 8'h01));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 1, 1, 1, 0, 8'h80));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h01, 1, 1, 0, 0, 8'h80));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 1, 1, 0, 0, 8'h80));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 2, 1, 1, 0, 8'h40));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 2, 1, 0, 0, 8'h40));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 3, 1, 1, 0, 8'h20));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 3, 1, 0, 0, 8'h20));
        tbl.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 8'hF0, 0, 1, 0, 0, 8'hF0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hF0, 0, 1, 0, 0, 8'hF0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hF0, 1, 1, 1, 0, 8'h78));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'hF0, 1, 0, 0, 0, 8'h78));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'hF0, 2, 0, 1, 0, 8'h3C));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'hF0, 3, 0, 1, 0, 8'h1E));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'hF0, 4, 0, 1, 0, 8'h0F));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'hF0, 5, 0, 1, 0, 8'h87));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hF0, 5, 0, 0, 0, 8'h87));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'hF0, 5, 1, 0, 0, 8'h87));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hF0, 5, 1, 0, 0, 8'h87));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'hF0, 5, 0, 0, 0, 8'h87));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hF0, 5, 0, 0, 0, 8'h87));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'hF0, 5, 1, 0, 0, 8'h87));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'hF0, 5, 1, 0, 0, 8'h87));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'hF0, 5, 1, 0, 0, 8'h87));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hF0, 5, 1, 0, 0, 8'h87));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hF0, 6, 1, 1, 0, 8'hC3));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hF0, 6, 1, 0, 0, 8'hC3));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'hF0, 6, 0, 0, 0, 8'hC3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'hF0, 6, 1, 0, 0, 8'hC3));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'hF0, 6, 0, 0, 0, 8'hC3));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h01, 7, 0, 1, 1, 8'h02));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h01, 6, 0, 1, 0, 8'h04));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h01, 6, 0, 0, 0, 8'h04));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h01, 6, 0, 0, 0, 8'h04));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h01, 6, 1, 0, 0, 8'h04));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h01, 6, 1, 0, 0, 8'h04));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 6, 1, 0, 0, 8'h04));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h01, 6, 1, 0, 0, 8'h04));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h01, 5, 1, 1, 0, 8'h08));

        foreach (tbl[i]) cyc(0, tbl[i], i);

        // Full up-count lap while running: wrap only on the 7->0 step.
        cyc(0, mk(1, 8'h01, 0, 0, 0, 0, 8'h01, 0, 1, 0, 0, 8'h01), 200);
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < 3; j++)
                cyc(0, mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 3'(k - 1), 1, 0, 0, yv[k - 1]), 200 + 4 * k + j);
            cyc(0, mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 3'(k % 8), 1, 1, (k == 8), yv[k % 8]), 203 + 4 * k);
        end

        idle_inputs(1'b0);
        #2 rst_r = 1'b1;
        #1 check_reset(2);
        @(negedge clk) rst_r = 1'b0;

        cyc(1, mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00), 300);
        for (int k = 1; k <= 8; k++)
            cyc(1, mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 3'(k % 8), 1, 1, (k == 8), 8'h00), 300 + k);
        cyc(1, mk(1, 8'h55, 0, 0, 0, 0, 8'h55, 0, 1, 0, 0, 8'h55), 310);
        cyc(1, mk(0, 8'h00, 0, 0, 0, 0, 8'h55, 1, 1, 1, 0, 8'hAA), 311);
        cyc(1, mk(0, 8'h00, 0, 1, 0, 0, 8'h55, 1, 0, 0, 0, 8'hAA), 312);
        cyc(1, mk(0, 8'h00, 0, 0, 1, 1, 8'h55, 0, 0, 1, 0, 8'h55), 313);
        cyc(1, mk(0, 8'h00, 0, 0, 1, 1, 8'h55, 7, 0, 1, 1, 8'hAA), 314);
        idle_inputs(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rot_stepper.md
Name: rot_stepper

Overview:
- Sequential control stage that sits directly upstream of the 8-bit rotate-right barrel shifter.
- Holds an 8-bit pattern and a 3-bit rotate amount, and steps the amount at a programmable rate or on demand.
- Drives the shifter's data input and amount input.
- Typical use: LED marquee / rotating display pattern. The shifter output y = rotr(a, amt) is consumed downstream unchanged.

Parameters:
- DIV_MAX, 4, clock cycles per automatic step; legal range >= 1.
- DIV_W, 23, width of the divider counter; must satisfy 2^DIV_W >= DIV_MAX.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe: capture din as the new pattern.
- din  input  8  pattern to load.
- start  input  1  strobe: enter RUN (automatic stepping).
- stop  input  1  strobe: return to IDLE.
- dir  input  1  0 = amt increments (rotate further right); 1 = amt decrements (rotates left).
- step_once  input  1  strobe: single manual step; honoured in IDLE only.
- a  output  8  registered pattern; feeds shifter input a.
- amt  output  3  registered rotate amount; feeds shifter input amt.
- running  output  1  1 while in RUN.
- step_tick  output  1  one-cycle pulse in the cycle after amt changes.
- wrap  output  1  one-cycle pulse coincident with step_tick when amt wrapped (7->0 up, 0->7 down).

Behaviour:
- Reset (asynchronous, immediate): a=0, amt=0, running=0, step_tick=0, wrap=0, divider cnt=0, state=IDLE.
- States: IDLE, RUN. The running output equals (state==RUN) and is registered.
- Per-edge priority: load > stop > start > step event. Exactly one action per cycle.
- load (any state):
  - a<=din, amt<=0, cnt<=0.
  - State unchanged: RUN keeps running from a fresh period.
  - No step_tick or wrap.
- stop:
  - state<=IDLE, cnt<=0.
  - amt and a are held.
  - stop while already in IDLE has no effect.
- start:
  - IDLE->RUN, cnt<=0.
  - start in RUN is ignored; cnt is not reset.
- RUN divider:
  - cnt counts 0..DIV_MAX-1.
  - On the edge where cnt==DIV_MAX-1: cnt<=0 and a step occurs.
  - First step therefore comes DIV_MAX cycles after the start edge.
  - DIV_MAX=1: a step every cycle.
- Step:
  - dir=0: amt<=amt+1 mod 8. dir=1: amt<=amt-1 mod 8.
  - dir is sampled at the step edge.
  - Changing dir mid-period does not reset cnt.
- step_once:
  - In IDLE: one step on the next edge.
  - In RUN: ignored.
  - Held high for k cycles in IDLE gives k steps; it is level-sampled, and the caller supplies strobes.
- step_tick / wrap:
  - Registered, high for exactly one cycle after each step edge; wrap as defined above.
  - Not asserted by load, stop or reset.
- Latency: a and amt change one edge after the causing input. The downstream shifter is combinational, so y is valid in the same cycle as a/amt.
- a changes only on load. The block never modifies pattern bits.
- Simultaneous events:
  - load with a divider terminal count: load wins, no step, cnt<=0.
  - stop with terminal count: no step.
  - start with step_once in IDLE: RUN entered, no step.
- Reset mid-RUN: immediate return to IDLE and all reset values. Pending strobes are lost.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN) and the DIR_UP/DIR_DN encodings.
- DIV_MAX/DIV_W stay as module parameters.
- One natural sub-module: rot_tick_gen.
  - A mod-DIV_MAX counter with enable and synchronous clear; outputs a terminal-count pulse.
  - Reusable for other timed display stages.
- Step/state logic stays in rot_stepper.

Test Plan:
- Reset + load: assert reset mid-operation, release, load din=8'b1000_0001 -> a=8'h81, amt=0, running=0, no step_tick.
- Auto step up: DIV_MAX=4, start, dir=0 -> amt 1,2,3 at cycles 4,8,12 after start edge; step_tick each time.
  - After 8 steps, amt=0 with wrap=1 on that step only.
  - Shifter y sequence for a=8'h01: 01,80,40,20.
- Down direction and wrap: from amt=0 in IDLE, dir=1, step_once 1 cycle -> amt=7, wrap=1.
  - Second strobe -> amt=6, wrap=0.
- Priority: load din=8'hF0 in the same cycle as terminal count while running -> a=8'hF0, amt=0, no step_tick, running stays 1, next step DIV_MAX cycles later.
- stop/start: stop at cnt=2 with amt=5 -> IDLE, amt holds 5.
  - step_once during RUN ignored.
  - start again -> next step exactly DIV_MAX cycles later; start while running does not delay it.
- DIV_MAX=1 build: start -> amt advances every cycle 1..7,0 with wrap on the 8th step.
